// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data memory that answers one CPU load/store at a time
//   with a fixed LATENCY-cycle delay and a one-cycle completion pulse.
//
//   Parameters
//     DEPTH     number of 32-bit words (power of two, 16..256)
//     LATENCY   edges from request acceptance to the Ready cycle (1..15)
//
//   Ports
//     Clock      in   sole clock, rising edge
//     Reset      in   synchronous active-high reset
//     Addr       in   byte address of the request
//     WriteData  in   store data
//     MemWrite   in   store request
//     MemRead    in   load request
//     ReadData   out  returned word, held between successful completions
//     Ready      out  one-cycle completion pulse
//     AddrErr    out  with Ready: request was rejected (misaligned/out of range)
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        AddrErr
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic [3:0]     cnt_r;
  logic [3:0]     cnt_nx_s;
  logic           accept_s;
  logic           access_s;

  logic [31:0]    addr_r;
  logic [31:0]    wdata_r;
  logic           is_write_r;

  logic           addr_ok_s;
  logic [AW-1:0]  idx_s;

  logic [31:0]    mem_r [DEPTH];

  // Captured address checks: word aligned and inside the array.
  assign addr_ok_s = (addr_r[1:0] == 2'b00) && (addr_r[31:AW+2] == '0);
  assign idx_s     = addr_r[AW+1:2];

  // State and latency counter register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state logic; access_s marks the edge on which the array is touched.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    accept_s   = 1'b0;
    access_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (MemWrite || MemRead) begin
          accept_s   = 1'b1;
          state_nx_s = BUSY;
          cnt_nx_s   = LAT_M1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != 4'd0) begin
          cnt_nx_s = cnt_r - 4'd1;
        end else begin
          access_s   = 1'b1;
          state_nx_s = RESP;
        end
      end
      // The edge leaving RESP never accepts, enforcing LATENCY+2 spacing.
      RESP: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // Request capture; inputs are ignored once the request is accepted.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      is_write_r <= 1'b0;
    end else if (accept_s) begin
      addr_r     <= Addr;
      wdata_r    <= WriteData;
      is_write_r <= MemWrite;     // write wins when both are high
    end
  end

  // Array write port; not cleared by reset, and a reset on the access edge
  // aborts the store.
  always_ff @(posedge Clock) begin
    if (!Reset && access_s && addr_ok_s && is_write_r) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  // Registered response. A successful write returns the stored word, so a
  // combined read+write yields the newly written data.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ReadData <= 32'h0000_0000;
      Ready    <= 1'b0;
      AddrErr  <= 1'b0;
    end else begin
      Ready   <= access_s;
      AddrErr <= access_s && !addr_ok_s;
      if (access_s && addr_ok_s) begin
        ReadData <= is_write_r ? wdata_r : mem_r[idx_s];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Ready;
  logic        AddrErr;

  int checks = 0;
  int errors = 0;

  // Reference model: plain word array plus the last returned word.
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] mdl_rd;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Addr      (Addr),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .Ready     (Ready),
    .AddrErr   (AddrErr)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Apply one request from IDLE, scramble inputs while it is in flight,
  // and check latency, error flag and data against the model.
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic r, output logic [31:0] got_rd, output logic got_err);
    int  n;
    bit  ok;
    Addr = a; WriteData = d; MemWrite = w; MemRead = r;
    step();
    Addr = $urandom; WriteData = $urandom;
    MemWrite = 1'($urandom_range(0, 1)); MemRead = 1'($urandom_range(0, 1));
    n = 0;
    while (!Ready && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(LATENCY));
    ok = (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
    if (ok) begin
      if (w) begin
        mdl_mem[int'(a >> 2)] = d;
        mdl_rd = d;
      end else begin
        mdl_rd = mdl_mem[int'(a >> 2)];
      end
    end
    chk("ready", {31'd0, Ready}, 32'd1);
    chk("addr_err", {31'd0, AddrErr}, {31'd0, !ok});
    chk("read_data", ReadData, mdl_rd);
    got_rd  = ReadData;
    got_err = AddrErr;
    // Edge leaving RESP: random requests present must not be accepted.
    step();
    chk("ready_low_after", {30'd0, Ready, AddrErr}, 32'd0);
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          n;

    Reset = 1'b1; Addr = 32'd0; WriteData = 32'd0; MemWrite = 1'b0; MemRead = 1'b0;
    mdl_rd = 32'd0;
    repeat (3) step();
    chk("reset_ready", {31'd0, Ready}, 32'd0);
    chk("reset_err", {31'd0, AddrErr}, 32'd0);
    chk("reset_rdata", ReadData, 32'd0);
    Reset = 1'b0;
    step();
    chk("idle_ready", {31'd0, Ready}, 32'd0);

    // Fill the array with a known pattern.
    for (int i = 0; i < DEPTH; i++) begin
      req(32'(i) << 2, 32'h1000_0000 + 32'(i), 1'b1, 1'b0, rd, er);
    end

    vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h0000_0010, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0000_0013, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{32'h0000_0100, 32'h5555_5555, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h1000_0000};
    vecs[5]  = '{32'h0000_000C, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[6]  = '{32'h0000_000C, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[7]  = '{32'h0000_00FC, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h1000_003F};
    vecs[8]  = '{32'h0000_0002, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h1000_003F};
    vecs[9]  = '{32'hFFFF_FFFC, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h1000_003F};
    vecs[10] = '{32'h0000_0008, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h1000_0002};

    for (int i = 0; i < 11; i++) begin
      req(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re, rd, er);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
    end

    // Inputs changed during BUSY must not affect the captured write.
    Addr = 32'h0000_0004; WriteData = 32'h1111_2222; MemWrite = 1'b1; MemRead = 1'b0;
    step();
    Addr = 32'h0000_0008; WriteData = 32'hFFFF_FFFF;
    n = 0;
    while (!Ready && n < 20) begin
      step();
      n++;
    end
    chk("busy_change_lat", 32'(n), 32'(LATENCY));
    chk("busy_change_err", {31'd0, AddrErr}, 32'd0);
    chk("busy_change_rd", ReadData, 32'h1111_2222);
    MemWrite = 1'b0;
    step();
    mdl_mem[1] = 32'h1111_2222;
    mdl_rd     = 32'h1111_2222;
    req(32'h0000_0004, 32'd0, 1'b0, 1'b1, rd, er);
    chk("word1_value", rd, 32'h1111_2222);
    req(32'h0000_0008, 32'd0, 1'b0, 1'b1, rd, er);
    chk("word2_unchanged", rd, 32'h1000_0002);

    // Reset while BUSY aborts the store and produces no Ready.
    Addr = 32'h0000_0020; WriteData = 32'h1234_5678; MemWrite = 1'b1;
    step();
    MemWrite = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    mdl_rd = 32'd0;
    chk("abort_rdata", ReadData, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_ready", {30'd0, Ready, AddrErr}, 32'd0);
      step();
    end
    req(32'h0000_0020, 32'd0, 1'b0, 1'b1, rd, er);
    chk("abort_word8", rd, 32'h1000_0008);

    // Requests held high continuously: Ready every LATENCY+2 edges.
    Addr = 32'h0000_0014; MemRead = 1'b1; MemWrite = 1'b0;
    for (int k = 1; k <= 4 * (LATENCY + 2); k++) begin
      step();
      chk($sformatf("cont_ready_e%0d", k), {31'd0, Ready},
          {31'd0, ((k - 1) % (LATENCY + 2)) == LATENCY});
      if (((k - 1) % (LATENCY + 2)) == LATENCY) begin
        chk("cont_rdata", ReadData, mdl_mem[5]);
      end
    end
    MemRead = 1'b0;
    mdl_rd = mdl_mem[5];
    step();

    // Randomised traffic against the model.
    for (int t = 0; t < 80; t++) begin
      int sel;
      int kind;
      sel  = $urandom_range(0, 9);
      kind = $urandom_range(1, 3);
      if (sel < 7) begin
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      end else if (sel == 7) begin
        a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      end else begin
        a = 32'(4 * DEPTH) | $urandom;
      end
      req(a, $urandom, kind[0], kind[1], rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
